// File: rtl/run_monitor.sv
// run_monitor: stretches reset to the core, counts run cycles and latches a
// pass / error / watchdog verdict that holds until the next rst.
module run_monitor #(
    parameter int unsigned RST_CYCLES = 2,       // edges core_rst stays high after rst, >= 1
    parameter int unsigned MAX_CYCLES = 100004,  // watchdog limit, < 2**CNT_W
    parameter int unsigned NUM_ERR    = 1,       // error channels, >= 1
    parameter int unsigned CNT_W      = 32       // cycle counter width
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_ERR-1:0] err,
    input  logic               halt,
    output logic               core_rst,
    output logic               running,
    output logic               done,
    output logic               pass,
    output logic               fail_err,
    output logic               fail_timeout,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [NUM_ERR-1:0] err_src,
    output logic [CNT_W-1:0]   err_cycle
);

    localparam int unsigned RW = $clog2(RST_CYCLES + 1);
    localparam logic [RW-1:0]    RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CYCLES);

    typedef enum logic [2:0] {
        StResetHold,
        StRun,
        StPass,
        StFailErr,
        StFailTimeout
    } state_e;

    state_e        state_q;
    logic [RW-1:0] rst_cnt_q;

    // State register, reset stretch counter, run counter and registered verdict outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StResetHold;
            rst_cnt_q    <= '0;
            core_rst     <= 1'b1;
            running      <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail_err     <= 1'b0;
            fail_timeout <= 1'b0;
            cycle_count  <= '0;
            err_src      <= '0;
            err_cycle    <= '0;
        end else begin
            case (state_q)
                StResetHold: begin
                    // err and halt are deliberately ignored while the core is held.
                    rst_cnt_q <= rst_cnt_q + 1'b1;
                    if (rst_cnt_q == RST_LAST) begin
                        state_q  <= StRun;
                        core_rst <= 1'b0;
                        running  <= 1'b1;
                    end
                end
                StRun: begin
                    // Error outranks halt, halt outranks the watchdog.
                    if (|err) begin
                        state_q   <= StFailErr;
                        err_src   <= err;
                        err_cycle <= cycle_count;
                        fail_err  <= 1'b1;
                        done      <= 1'b1;
                        running   <= 1'b0;
                        core_rst  <= 1'b1;
                    end else if (halt) begin
                        state_q  <= StPass;
                        pass     <= 1'b1;
                        done     <= 1'b1;
                        running  <= 1'b0;
                        core_rst <= 1'b1;
                    end else if (cycle_count == CNT_MAX) begin
                        state_q      <= StFailTimeout;
                        fail_timeout <= 1'b1;
                        done         <= 1'b1;
                        running      <= 1'b0;
                        core_rst     <= 1'b1;
                    end else begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                end
                default: begin
                    // Terminal states: everything frozen until rst.
                    state_q <= state_q;
                end
            endcase
        end
    end

endmodule
